skid_buffer: RTL



---
 rtl/skid_buffer.sv | 109 ++++++++++
 1 files changed

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry valid/ready skid buffer with synchronous flush
// Optional backpressure cycle counter under `SKID_BUFFER_STALL_CNT_EN`.
module skid_buffer #(
  parameter int width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] out_data_o,
  output logic [31:0]      stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [width-1:0]   main_q, main_d;
  logic [width-1:0]   skid_q, skid_d;
  logic               in_xfer;
  logic               out_xfer;

  // Ready depends only on state, so the consumer's ready never reaches the producer combinationally.
  assign out_valid_o = (state_q != EMPTY);
  assign in_ready_o  = (state_q != SKID);
  assign out_data_o  = main_q;

  assign in_xfer  = in_valid_i && in_ready_o;
  assign out_xfer = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = FULL;
            main_d  = in_data_i;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data_i;
          end else if (in_xfer) begin
            state_d = SKID;
            skid_d  = in_data_i;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_xfer) begin
            state_d = FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef SKID_BUFFER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Flush deliberately leaves the count alone; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (out_valid_o && !out_ready_i) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
